sop_pla_pipe: RTL and testbench

//  Programmable sum-of-products (PLA) evaluator, generalising fixed SOP gates.
//  N_TERM product terms over N_IN inputs, each programmable (enable, care mask, polarity);
//  N_OUT outputs, each an OR over a programmable subset of terms.
//  Two-stage pipeline with valid/ready on input and output, config-write port for the arrays.

---
 rtl/sop_pla_pipe_if.sv | 34 +++
 rtl/sop_pla_pipe.sv | 115 +++++++++++
 tb/tb_sop_pla_pipe.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/sop_pla_pipe_if.sv
// sop_pla_pipe_if: bundle of all handshake/bus signals of sop_pla_pipe.
//   in_valid/in_ready/in_data      input vector stream
//   out_valid/out_ready/out_data   SOP result stream
//   cfg_we/cfg_ready/cfg_addr/cfg_data/cfg_err   config-write port
// slave  = the PLA block, master = the requester/consumer side.
interface sop_pla_pipe_if #(
  parameter int N_IN   = 3,
  parameter int N_TERM = 4,
  parameter int N_OUT  = 1
);
  localparam int CW = (2*N_IN+1 > N_TERM) ? 2*N_IN+1 : N_TERM;
  localparam int AW = (N_TERM+N_OUT > 2) ? $clog2(N_TERM+N_OUT) : 1;

  logic              in_valid;
  logic              in_ready;
  logic [N_IN-1:0]   in_data;
  logic              out_valid;
  logic              out_ready;
  logic [N_OUT-1:0]  out_data;
  logic              cfg_we;
  logic              cfg_ready;
  logic [AW-1:0]     cfg_addr;
  logic [CW-1:0]     cfg_data;
  logic              cfg_err;

  modport slave (
    input  in_valid, in_data, out_ready, cfg_we, cfg_addr, cfg_data,
    output in_ready, out_valid, out_data, cfg_ready, cfg_err
  );
  modport master (
    output in_valid, in_data, out_ready, cfg_we, cfg_addr, cfg_data,
    input  in_ready, out_valid, out_data, cfg_ready, cfg_err
  );
endinterface

// File: rtl/sop_pla_pipe.sv
// sop_pla_pipe: programmable sum-of-products evaluator, two pipeline stages.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    sop_pla_pipe_if.slave: input stream, output stream, config port
// Stage 1 registers the product terms, stage 2 registers the OR planes.
// Term entry:   cfg_data[0]=en, [N_IN:1]=mask, [2*N_IN:N_IN+1]=val.
// Output entry: cfg_data[N_TERM-1:0]=or_sel.
module sop_pla_pipe #(
  parameter int N_IN   = 3,
  parameter int N_TERM = 4,
  parameter int N_OUT  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  sop_pla_pipe_if.slave    bus
);
  localparam int AW = (N_TERM+N_OUT > 2) ? $clog2(N_TERM+N_OUT) : 1;

  logic [N_TERM-1:0]            r_en;
  logic [N_TERM-1:0][N_IN-1:0]  r_mask;
  logic [N_TERM-1:0][N_IN-1:0]  r_val;
  logic [N_OUT-1:0][N_TERM-1:0] r_or_sel;
  logic [N_TERM-1:0]            r_s1_prod;
  logic                         r_s1_valid;
  logic                         r_s2_valid;
  logic [N_OUT-1:0]             r_out_data;
  logic                         r_cfg_err;

  logic              w_cfg_ready, w_cfg_take, w_in_ready, w_in_fire, w_s2_load;
  logic              w_addr_ok;
  logic [N_TERM-1:0] w_prod;
  logic [N_OUT-1:0]  w_sop;

  // Config may only land while nothing is in flight, so no vector ever
  // straddles two configurations.
  assign w_cfg_ready = !r_s1_valid && !r_s2_valid;
  assign w_cfg_take  = bus.cfg_we && w_cfg_ready;
  assign w_s2_load   = r_s1_valid && (!r_s2_valid || bus.out_ready);
  // A config write steals the cycle from the input stream.
  assign w_in_ready  = (!r_s1_valid || w_s2_load) && !w_cfg_take;
  assign w_in_fire   = bus.in_valid && w_in_ready;

  assign bus.in_ready  = w_in_ready;
  assign bus.cfg_ready = w_cfg_ready;
  assign bus.out_valid = r_s2_valid;
  assign bus.out_data  = r_out_data;
  assign bus.cfg_err   = r_cfg_err;

  // AND plane: a bit with mask=0 is don't-care, otherwise must equal val.
  always_comb begin
    w_prod = '0;
    for (int t = 0; t < N_TERM; t++)
      w_prod[t] = r_en[t] & (&(~r_mask[t] | ~(bus.in_data ^ r_val[t])));
  end

  // OR plane on the registered terms.
  always_comb begin
    w_sop = '0;
    for (int o = 0; o < N_OUT; o++)
      w_sop[o] = |(r_s1_prod & r_or_sel[o]);
  end

  always_comb begin
    w_addr_ok = 1'b0;
    for (int a = 0; a < N_TERM+N_OUT; a++)
      if (bus.cfg_addr == AW'(a)) w_addr_ok = 1'b1;
  end

  // Config arrays; an out-of-range address matches no entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en      <= '0;
      r_mask    <= '0;
      r_val     <= '0;
      r_or_sel  <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= w_cfg_take && !w_addr_ok;
      if (w_cfg_take) begin
        for (int t = 0; t < N_TERM; t++)
          if (bus.cfg_addr == AW'(t)) begin
            r_en[t]   <= bus.cfg_data[0];
            r_mask[t] <= bus.cfg_data[N_IN:1];
            r_val[t]  <= bus.cfg_data[2*N_IN:N_IN+1];
          end
        for (int o = 0; o < N_OUT; o++)
          if (bus.cfg_addr == AW'(N_TERM+o))
            r_or_sel[o] <= bus.cfg_data[N_TERM-1:0];
      end
    end
  end

  // Pipeline: stage 2 holds while stalled, stage 1 drains into it when it can.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_prod  <= '0;
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_out_data <= '0;
    end else begin
      if (w_in_fire) begin
        r_s1_prod  <= w_prod;
        r_s1_valid <= 1'b1;
      end else if (w_s2_load) begin
        r_s1_valid <= 1'b0;
      end
      if (w_s2_load) begin
        r_out_data <= w_sop;
        r_s2_valid <= 1'b1;
      end else if (bus.out_ready) begin
        r_s2_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sop_pla_pipe.sv
module tb_sop_pla_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sop_pla_pipe_if #(.N_IN(3), .N_TERM(4), .N_OUT(1)) bus ();
  sop_pla_pipe #(.N_IN(3), .N_TERM(4), .N_OUT(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  int checks = 0;
  int failures = 0;
  logic [0:0] q[$];
  int cyc = 0;
  int acc_cnt = 0;
  bit lat_arm = 0;
  int first_acc = -1, first_out = -1, last_out = -1;
  bit prev_stall = 0;
  logic [0:0] prev_data = '0;
  logic [7:0] ftab;  // f=~x~z|~yz, bit i = f(i)

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expected results on every output handshake and checks
  // the output is frozen during a stall.
  always @(negedge clk) begin
    if (!rst_n) prev_stall = 0;
    else begin
      if (prev_stall) begin
        chk("hold_valid", {31'd0, bus.out_valid}, 1);
        chk("hold_data", {31'd0, bus.out_data}, {31'd0, prev_data});
      end
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_out: got %0h expected none", bus.out_data);
        end else chk("out_data", {31'd0, bus.out_data}, {31'd0, q.pop_front()});
        if (lat_arm && first_out < 0) first_out = cyc;
        last_out = cyc;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
    end
  end

  // All drive tasks start and end at posedge+1.
  task automatic send(input logic [2:0] v, input logic e);
    bit got = 0;
    bus.in_valid = 1'b1; bus.in_data = v;
    for (int k = 0; k < 64 && !got; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        q.push_back(e); acc_cnt++; got = 1;
        if (lat_arm && first_acc < 0) first_acc = cyc;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    if (!got) chk("send_timeout", 0, 1);
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [6:0] d);
    bit got = 0;
    bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_data = d;
    for (int k = 0; k < 64 && !got; k++) begin
      @(negedge clk);
      if (bus.cfg_ready) got = 1;
      @(posedge clk); #1;
    end
    bus.cfg_we = 1'b0;
    if (!got) chk("cfg_timeout", 0, 1);
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 200 && (q.size() != 0 || bus.out_valid); k++) begin
      @(posedge clk); #1;
    end
    chk("drain", q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    ftab = 8'h27;
    bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 1;
    bus.cfg_we = 0; bus.cfg_addr = '0; bus.cfg_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: reset state
    chk("rst_out_valid", {31'd0, bus.out_valid}, 0);
    chk("rst_cfg_ready", {31'd0, bus.cfg_ready}, 1);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 1);
    chk("rst_cfg_err", {31'd0, bus.cfg_err}, 0);
    send(3'b000, 1'b0);
    wait_drain();

    // 2: program and stream back-to-back
    cfg_write(3'd0, 7'h0B);
    cfg_write(3'd1, 7'h17);
    cfg_write(3'd4, 7'h03);
    lat_arm = 1;
    for (int i = 0; i < 8; i++) send(i[2:0], ftab[i]);
    wait_drain();
    lat_arm = 0;
    chk("latency", first_out - first_acc, 2);
    chk("back_to_back", last_out - first_out, 7);

    // 3: backpressure
    bus.out_ready = 0; acc_cnt = 0;
    fork
      for (int i = 0; i < 8; i++) send(i[2:0], ftab[i]);
      begin
        repeat (5) @(posedge clk); #1;
        chk("bp_accepted", acc_cnt, 2);
        chk("bp_in_ready", {31'd0, bus.in_ready}, 0);
        chk("bp_out_valid", {31'd0, bus.out_valid}, 1);
        bus.out_ready = 1;
      end
    join
    wait_drain();

    // 4: config/input collision; or_sel -> only ~x~z
    bus.cfg_we = 1; bus.cfg_addr = 3'd4; bus.cfg_data = 7'h01;
    bus.in_valid = 1; bus.in_data = 3'b001;
    @(negedge clk);
    chk("col_cfg_ready", {31'd0, bus.cfg_ready}, 1);
    chk("col_in_ready", {31'd0, bus.in_ready}, 0);
    @(posedge clk); #1;
    bus.cfg_we = 0;
    @(negedge clk);
    chk("col_in_next", {31'd0, bus.in_ready}, 1);
    if (bus.in_ready) q.push_back(1'b0);
    @(posedge clk); #1;
    bus.in_valid = 0;
    bus.cfg_we = 1; bus.cfg_addr = 3'd4; bus.cfg_data = 7'h03;
    @(negedge clk);
    chk("busy_cfg_ready", {31'd0, bus.cfg_ready}, 0);
    @(posedge clk); #1;
    cfg_write(3'd4, 7'h03);
    wait_drain();
    send(3'b001, 1'b1);
    wait_drain();

    // 5: bad address
    chk("pre_err", {31'd0, bus.cfg_err}, 0);
    cfg_write(3'd5, 7'h7F);
    chk("err_pulse", {31'd0, bus.cfg_err}, 1);
    @(posedge clk); #1;
    chk("err_clear", {31'd0, bus.cfg_err}, 0);
    for (int i = 0; i < 8; i++) send(i[2:0], ftab[i]);
    wait_drain();

    // 6: async reset with two vectors in flight
    bus.out_ready = 0;
    send(3'b000, 1'b1);
    send(3'b101, 1'b1);
    chk("pre_rst_valid", {31'd0, bus.out_valid}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_valid", {31'd0, bus.out_valid}, 0);
    chk("rst_async_cfg_ready", {31'd0, bus.cfg_ready}, 1);
    q.delete();
    @(negedge clk) rst_n = 1'b1;
    bus.out_ready = 1;
    @(posedge clk); #1;
    send(3'b000, 1'b0);
    send(3'b101, 1'b0);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
